// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: start/busy/done handshake, operands and HI/LO view of the multiply/divide unit
interface muldiv_hilo_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] op;
  logic sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, sgn, a, b, input busy, done, dz, hi, lo);
  modport slave(input start, op, sgn, a, b, output busy, done, dz, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative shift-add multiply / restoring divide owning HI/LO; SIGNED_MULDIV_EN enables signed MULT/DIV
module muldiv_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic clk,
  input logic rst,
  muldiv_hilo_if.slave m
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, mb, hi_r, lo_r;
  logic busy_r, done_r, dz_r, neg_q, neg_r, sg, ge;
  logic [WIDTH-1:0] ma_in, mb_in, acc_m, q_m, acc_d, q_d;
  logic [WIDTH:0] sum, sh;
  logic [2*WIDTH-1:0] prod;
`ifdef SIGNED_MULDIV_EN
  assign sg = m.sgn;
`else
  assign sg = m.sgn & 1'b0;
`endif
  assign m.busy = busy_r;
  assign m.done = done_r;
  assign m.dz = dz_r;
  assign m.hi = hi_r;
  assign m.lo = lo_r;
  // operand magnitudes at accept and one step of each iterative engine
  always_comb begin
    ma_in = sg && m.a[WIDTH-1] ? -m.a : m.a;
    mb_in = sg && m.b[WIDTH-1] ? -m.b : m.b;
    sum = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
    acc_m = sum[WIDTH:1];
    q_m = {sum[0], q[WIDTH-1:1]};
    sh = {acc, q[WIDTH-1]};
    ge = sh >= {1'b0, mb};
    acc_d = ge ? WIDTH'(sh - {1'b0, mb}) : sh[WIDTH-1:0];
    q_d = {q[WIDTH-2:0], ge};
    prod = neg_q ? -{acc_m, q_m} : {acc_m, q_m};
  end
  // control FSM, iteration registers and architectural HI/LO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      mb <= '0;
      hi_r <= '0;
      lo_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r <= 1'b0;
      if (state == MUL || state == DIV) begin
        if (state == DIV && mb == '0) begin
          state <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          dz_r <= 1'b1;
        end else begin
          acc <= state == MUL ? acc_m : acc_d;
          q <= state == MUL ? q_m : q_d;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            if (state == MUL) {hi_r, lo_r} <= prod;
            else begin
              hi_r <= neg_r ? -acc_d : acc_d;
              lo_r <= neg_q ? -q_d : q_d;
            end
          end
        end
      end else if (m.start) begin
        cnt <= '0;
        acc <= '0;
        q <= ma_in;
        mb <= mb_in;
        neg_q <= sg && (m.a[WIDTH-1] ^ m.b[WIDTH-1]);
        neg_r <= sg && m.a[WIDTH-1];
        state <= m.op == 2'b00 ? MUL : m.op == 2'b01 ? DIV : IDLE;
        busy_r <= !m.op[1];
        if (m.op == 2'b10) hi_r <= m.a;
        if (m.op == 2'b11) lo_r <= m.a;
      end else state <= IDLE;
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed vectors for muldiv_hilo; expectations follow SIGNED_MULDIV_EN
module tb_muldiv_hilo;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0;
  int n_cmp = 0, n_bad = 0, n;
`ifdef SIGNED_MULDIV_EN
  localparam logic [63:0] E_SDIV = {32'hFFFFFFFF, 32'hFFFFFFFD};
  localparam logic [63:0] E_SMUL = 64'hFFFFFFFF_FFFFFFF4;
  localparam logic [63:0] E_MIN = {32'h0, 32'h80000000};
`else
  localparam logic [63:0] E_SDIV = {32'h1, 32'h7FFFFFFC};
  localparam logic [63:0] E_SMUL = 64'h3_FFFFFFF4;
  localparam logic [63:0] E_MIN = {32'h80000000, 32'h0};
`endif
  muldiv_hilo_if #(.WIDTH(32)) m();
  muldiv_hilo #(.WIDTH(32), .CNT_W(5)) dut(.clk(clk), .rst(rst), .m(m.slave));
  always #5 clk = clk_en ? ~clk : clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    m.op = op;
    m.a = a;
    m.b = b;
    m.sgn = s;
    m.start = 1'b1;
    @(posedge clk);
    #1 m.start = 1'b0;
  endtask
  task automatic wait_done(output int k);
    k = 0;
    while (m.done !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1 k++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    m.start = 1'b0;
    m.op = 2'b00;
    m.a = '0;
    m.b = '0;
    m.sgn = 1'b0;
    #3 rst = 1'b1;
    #1 check("rst_hilo", {m.hi, m.lo}, 64'h0);
    check("rst_flags", {m.busy, m.done, m.dz}, 3'b000);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 check("idle", {m.busy, m.done, m.dz, m.hi | m.lo}, 35'h0);
    end
    go(2'b00, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("mul_busy", m.busy, 1'b1);
    wait_done(n);
    check("mul_lat", n, 32);
    check("mul_hilo", {m.hi, m.lo}, 64'h1_FFFFFFFE);
    check("mul_flags", {m.busy, m.dz}, 2'b00);
    go(2'b01, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    m.a = 32'd5;
    m.start = 1'b1;
    @(posedge clk);
    #1 m.start = 1'b0;
    wait_done(n);
    check("div_lat", n, 22);
    check("div_hilo", {m.hi, m.lo}, {32'd2, 32'd14});
    check("div_dz", m.dz, 1'b0);
    go(2'b10, 32'h11, 32'h0, 1'b0);
    check("mthi", {m.busy, m.done, m.hi}, {2'b00, 32'h11});
    go(2'b11, 32'h22, 32'h0, 1'b0);
    check("mtlo", {m.busy, m.done, m.lo}, {2'b00, 32'h22});
    go(2'b01, 32'd9, 32'd0, 1'b0);
    wait_done(n);
    check("dz_lat", n, 1);
    check("dz_flags", {m.done, m.dz}, 2'b11);
    check("dz_hilo", {m.hi, m.lo}, {32'h11, 32'h22});
    @(posedge clk);
    #1 check("dz_clear", {m.done, m.dz}, 2'b00);
    go(2'b00, 32'd3, 32'd5, 1'b0);
    repeat (16) @(posedge clk);
    #1 check("mid_hilo", {m.hi, m.lo}, {32'h11, 32'h22});
    check("mid_busy", m.busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("abort_hilo", {m.hi, m.lo}, 64'h0);
    check("abort_flags", {m.busy, m.done}, 2'b00);
    @(negedge clk) rst = 1'b0;
    go(2'b00, 32'd3, 32'd5, 1'b0);
    wait_done(n);
    check("mul2_lat", n, 32);
    check("mul2_hilo", {m.hi, m.lo}, 64'd15);
    go(2'b01, 32'hFFFFFFF9, 32'h2, 1'b1);
    wait_done(n);
    check("sdiv_lat", n, 32);
    check("sdiv_hilo", {m.hi, m.lo}, E_SDIV);
    go(2'b00, 32'hFFFFFFFD, 32'h4, 1'b1);
    wait_done(n);
    check("smul_hilo", {m.hi, m.lo}, E_SMUL);
    go(2'b01, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(n);
    check("smin_hilo", {m.hi, m.lo}, E_MIN);
    check("smin_dz", m.dz, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
